// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: steps one shared full-adder cell LSB-first,
// one bit per clock, and presents sum, carry-out and signed overflow with a done pulse.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_cout;
    logic             c_msb_in;
    logic             at_msb;

    // The shared full-adder cell; the carry into the MSB is kept for overflow.
    assign fa_s     = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_cout  = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign c_msb_in = carry;
    assign at_msb   = (cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (at_msb) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Subtraction is a + ~b + 1: B is inverted at accept and the carry seeds the +1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res_sh <= {fa_s, res_sh[WIDTH-1:1]};
                    carry  <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    if (at_msb) begin
                        sum  <= {fa_s, res_sh[WIDTH-1:1]};
                        cout <= fa_cout;
                        ovf  <= c_msb_in ^ fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random operations
// compared against an integer-arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;
    logic         prev_ovf  = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic refModel(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_sub,
                            output logic [W-1:0] e_sum, output logic e_cout, output logic e_ovf);
        int ua, ub, sa, sb, raw, sr;
        ua    = int'(op_a);
        ub    = int'(op_b);
        sa    = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb    = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        raw   = op_sub ? ua - ub : ua + ub;
        sr    = op_sub ? sa - sb : sa + sb;
        e_sum = W'(raw & ((1 << W) - 1));
        e_cout = op_sub ? (ua >= ub) : (raw >= (1 << W));
        e_ovf  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                 input logic op_sub, input int intrude_at);
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
        refModel(op_a, op_b, op_sub, e_sum, e_cout, e_ovf);
        a = op_a;
        b = op_b;
        sub = op_sub;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        checkOutput("done_after_accept", 32'(done), 32'd0);
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            checkOutput("done_timing", 32'(done), 32'(k == W));
            checkOutput("busy_timing", 32'(busy), 32'(k <= W));
            if (k < W) begin
                checkOutput("sum_hold", 32'(sum), 32'(prev_sum));
                checkOutput("cout_hold", 32'(cout), 32'(prev_cout));
                checkOutput("ovf_hold", 32'(ovf), 32'(prev_ovf));
            end else begin
                checkOutput("sum", 32'(sum), 32'(e_sum));
                checkOutput("cout", 32'(cout), 32'(e_cout));
                checkOutput("ovf", 32'(ovf), 32'(e_ovf));
            end
            if (k == intrude_at) begin
                start = 1'b1;
                a = 8'hAA;
                b = 8'h55;
            end else begin
                start = 1'b0;
            end
        end
        prev_sum  = e_sum;
        prev_cout = e_cout;
        prev_ovf  = e_ovf;
    endtask

    initial begin
        int pulses;
        int last_cyc;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(8'h35, 8'h4A, 1'b0, -1);
        applyStimulus(8'hFF, 8'h01, 1'b0, -1);
        applyStimulus(8'h7F, 8'h01, 1'b0, -1);
        applyStimulus(8'h10, 8'h20, 1'b1, -1);
        applyStimulus(8'h80, 8'h01, 1'b1, -1);
        applyStimulus(8'h01, 8'h01, 1'b0, 3);
        @(negedge clk);
        checkOutput("ignored_start_idle", 32'(busy), 32'd0);

        // Abort mid-operation with an asynchronous reset.
        applyStimulus(8'h35, 8'h4A, 1'b0, -1);
        a = 8'h11;
        b = 8'h22;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        checkOutput("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        checkOutput("abort_done_held", 32'(done), 32'd0);
        rst_n = 1'b1;
        prev_sum  = '0;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;
        @(negedge clk);
        checkOutput("post_abort_busy", 32'(busy), 32'd0);
        applyStimulus(8'h03, 8'h04, 1'b0, -1);

        // Back-to-back operations with start held high.
        a = 8'h01;
        b = 8'h02;
        sub = 1'b0;
        start = 1'b1;
        pulses = 0;
        last_cyc = 0;
        for (int cyc = 1; cyc <= 40 && pulses < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                checkOutput("b2b_sum", 32'(sum), 32'h03);
                if (pulses > 0) begin
                    checkOutput("b2b_spacing", 32'(cyc - last_cyc), 32'(W + 2));
                end
                last_cyc = cyc;
                pulses++;
            end
        end
        start = 1'b0;
        checkOutput("b2b_pulses", 32'(pulses), 32'd3);
        repeat (2) @(negedge clk);
        checkOutput("b2b_idle", 32'(busy), 32'd0);
        prev_sum  = 8'h03;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;

        for (int i = 0; i < 25; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract controller built around a single 1-bit full-adder cell.
- Latches two WIDTH-bit operands on a start request, then steps the full adder LSB-first, one bit per clock, through a carry flip-flop.
- Presents the registered sum, carry-out and signed overflow with a one-cycle done pulse.
- Sits between a requesting datapath/FSM and the shared FA cell; trades area for WIDTH-cycle latency.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range WIDTH >= 2).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, operation request; sampled only in IDLE.
- sub, input, 1, 0 = a+b, 1 = a-b; sampled with start.
- a, input, WIDTH, operand A; sampled with start.
- b, input, WIDTH, operand B; sampled with start.
- busy, output, 1, high in RUN and DONE.
- done, output, 1, one-cycle pulse; results valid.
- sum, output, WIDTH, result register.
- cout, output, 1, final carry-out (for sub: 1 = no borrow).
- ovf, output, 1, two's-complement overflow.

Behaviour:
- Reset (rst_n=0, async): state=IDLE. busy=0, done=0, sum=0, cout=0, ovf=0. All internal shift registers, carry flip-flop and bit counter are cleared.
- Reset asserted mid-operation aborts immediately. No done pulse is produced and outputs return to their reset values.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on a clock edge with start=1.
  - RUN -> DONE on the edge that processes bit WIDTH-1.
  - DONE -> IDLE unconditionally on the next edge.
- Accept edge (edge 0):
  - a_sh <= a, b_sh <= b ^ {WIDTH{sub}}, sub_r <= sub.
  - carry <= sub (supplies the +1 for two's-complement subtract).
  - cnt <= 0.
- RUN edge k (k = 1..WIDTH):
  - FA inputs: a_sh[0], b_sh[0], carry.
  - Result bit s shifts into the MSB of res_sh; carry <= cout_fa.
  - a_sh and b_sh shift right by one.
  - cnt increments.
  - On the edge where cnt = WIDTH-1, capture c_msb_in = carry before update, for overflow.
- Last RUN edge (edge WIDTH):
  - sum <= final res_sh value including the bit computed this cycle.
  - cout <= carry-out of bit WIDTH-1.
  - ovf <= c_msb_in ^ carry-out of bit WIDTH-1.
  - State becomes DONE.
- Output timing:
  - done=1 during the DONE cycle only: high after edge WIDTH, low after edge WIDTH+1.
  - busy rises after edge 0 and falls after edge WIDTH+1.
  - Latency: start edge to done high = WIDTH clocks. Throughput: one operation per WIDTH+2 clocks, since the next start can be accepted on the edge leaving DONE+1 (state IDLE).
- sum/cout/ovf hold the previous result throughout RUN and change only on the last RUN edge. They hold until the next operation's last RUN edge.
- start while busy (RUN or DONE) is ignored; there is no queuing and operand changes are ignored.
- start held continuously re-triggers on each IDLE cycle (back-to-back operations).
- Arithmetic is modulo 2^WIDTH. cout and ovf are both computed and the requester decides which applies (unsigned vs signed).

Test Plan:
- WIDTH=8, start with a=0x35, b=0x4A, sub=0 -> done high exactly 8 clocks after the accept edge; sum=0x7F, cout=0, ovf=0; busy high for 9 cycles.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- sub=1: a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Pulse start with a=0x01, b=0x01 at accept, then pulse start with a=0xAA, b=0x55 at cycle 3 -> second request ignored; sum=0x02; exactly one done pulse.
- After a completed op with sum=0x7F, start a new op, then drop rst_n at cycle 4 of RUN -> all outputs 0 immediately, no done. After release, start a=0x03, b=0x04 -> sum=0x07 with normal latency.
- start held high for 3 ops with fixed a=0x01, b=0x02 -> done pulses spaced WIDTH+2=10 clocks apart, each with sum=0x03.
